// File: rtl/fht_loader.sv
// -----------------------------------------------------------------------------
// fht_loader
//
// Input-side writer for the FHT core. Takes a stream of N = 2**N_BIT real
// samples over a valid/ready handshake and scatters them across the four
// input RAM banks in the order the FHT expects. When a frame is complete it
// pulses oFRAME_DONE, then oSTART. It then refuses new data until the
// controller has gone busy and come back to ready.
//
// Build option:
//   FHT_LOADER_NATURAL_ORDER_EN  defined   -> sample k goes to bank k[1:0],
//                                            address k[9:2] (the source already
//                                            delivers bit-reversed order)
//                                undefined -> r = bitrev(k); bank r[1:0],
//                                            address r[9:2]
//
// Ports:
//   iCLK         clock, rising edge
//   iRESET       asynchronous active-high reset
//   iDATA        input sample
//   iVALID       iDATA valid
//   oREADY       high while the loader accepts samples
//   iABORT       synchronous frame discard (ignored while the FHT runs)
//   iFHT_RDY     controller idle flag
//   oSTART       one-cycle start pulse to the controller
//   oADDR_WR     bank write address, shared by all banks
//   oDATA_WR     bank write data, shared by all banks
//   oWE_0..oWE_3 per-bank write enables, one-hot or zero
//   oCNT         samples accepted in the current frame
//   oFRAME_DONE  one-cycle pulse alongside the last write of a frame
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module fht_loader #(
   parameter int unsigned A_BIT = 8,
   parameter int unsigned D_BIT = 16,
   parameter int unsigned N_BIT = 10
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iDATA,
   input  logic             iVALID,
   output logic             oREADY,
   input  logic             iABORT,
   input  logic             iFHT_RDY,
   output logic             oSTART,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA_WR,
   output logic             oWE_0,
   output logic             oWE_1,
   output logic             oWE_2,
   output logic             oWE_3,
   output logic [N_BIT-1:0] oCNT,
   output logic             oFRAME_DONE
);

   // Four banks of 2**A_BIT words must cover the whole frame exactly.
   if (N_BIT != A_BIT + 2) begin : g_param_check
      $error("fht_loader: N_BIT must equal A_BIT + 2");
   end

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFlush,
      StStart,
      StWaitBusy,
      StWaitDone
   } state_t;

   state_t           state;
   logic [3:0]       we_q;
   logic [N_BIT-1:0] wr_index;
   logic [1:0]       wr_bank;
   logic [A_BIT-1:0] wr_addr;
   logic             accept;
   logic             abort_en;

`ifdef FHT_LOADER_NATURAL_ORDER_EN
   assign wr_index = oCNT;
`else
   function automatic logic [N_BIT-1:0] bitrev(input logic [N_BIT-1:0] v);
      logic [N_BIT-1:0] r;
      for (int i = 0; i < N_BIT; i++) begin
         r[i] = v[N_BIT-1-i];
      end
      return r;
   endfunction

   assign wr_index = bitrev(oCNT);
`endif

   // oCNT is the index of the sample being accepted this cycle.
   assign wr_bank  = wr_index[1:0];
   assign wr_addr  = wr_index[A_BIT+1:2];
   assign accept   = iVALID & oREADY;
   // A running FHT cannot be cancelled, so abort is dead while waiting on it.
   assign abort_en = iABORT && (state != StWaitBusy) && (state != StWaitDone);

   assign oWE_0 = we_q[0];
   assign oWE_1 = we_q[1];
   assign oWE_2 = we_q[2];
   assign oWE_3 = we_q[3];

   // oREADY is kept registered alongside the state: it is high exactly in StLoad.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state       <= StIdle;
         oREADY      <= 1'b0;
         oSTART      <= 1'b0;
         oFRAME_DONE <= 1'b0;
         oCNT        <= '0;
         we_q        <= '0;
         oADDR_WR    <= '0;
         oDATA_WR    <= '0;
      end else begin
         // Pulses and write enables last one cycle unless re-armed below.
         we_q        <= '0;
         oSTART      <= 1'b0;
         oFRAME_DONE <= 1'b0;

         if (abort_en) begin
            state  <= StIdle;
            oREADY <= 1'b0;
            oCNT   <= '0;
         end else begin
            if (accept) begin
               we_q     <= 4'b0001 << wr_bank;
               oADDR_WR <= wr_addr;
               oDATA_WR <= iDATA;
               oCNT     <= oCNT + N_BIT'(1);  // wraps to 0 on the last sample
            end

            unique case (state)
               StIdle: begin
                  if (iFHT_RDY) begin
                     state  <= StLoad;
                     oREADY <= 1'b1;
                  end
               end
               StLoad: begin
                  if (accept && (oCNT == '1)) begin
                     // Last write lands during StFlush, together with the done pulse.
                     state       <= StFlush;
                     oREADY      <= 1'b0;
                     oFRAME_DONE <= 1'b1;
                  end else if (!iFHT_RDY) begin
                     // Controller was started elsewhere; keep oCNT and resume later.
                     state  <= StWaitDone;
                     oREADY <= 1'b0;
                  end
               end
               StFlush: begin
                  state  <= StStart;
                  oSTART <= 1'b1;
               end
               StStart: begin
                  state <= StWaitBusy;
               end
               StWaitBusy: begin
                  if (!iFHT_RDY) begin
                     state <= StWaitDone;
                  end
               end
               StWaitDone: begin
                  if (iFHT_RDY) begin
                     state  <= StLoad;
                     oREADY <= 1'b1;
                  end
               end
               default: begin
                  state  <= StIdle;
                  oREADY <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fht_loader.sv
`timescale 1ns / 1ps

module tb_fht_loader;

   localparam int A_BIT = 8;
   localparam int D_BIT = 16;
   localparam int N_BIT = 10;
   localparam int N     = 1024;

   logic             iCLK = 1'b0;
   logic             iRESET;
   logic [D_BIT-1:0] iDATA;
   logic             iVALID;
   logic             oREADY;
   logic             iABORT;
   logic             iFHT_RDY;
   logic             oSTART;
   logic [A_BIT-1:0] oADDR_WR;
   logic [D_BIT-1:0] oDATA_WR;
   logic             oWE_0, oWE_1, oWE_2, oWE_3;
   logic [N_BIT-1:0] oCNT;
   logic             oFRAME_DONE;

   fht_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT), .N_BIT(N_BIT)) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iDATA      (iDATA),
      .iVALID     (iVALID),
      .oREADY     (oREADY),
      .iABORT     (iABORT),
      .iFHT_RDY   (iFHT_RDY),
      .oSTART     (oSTART),
      .oADDR_WR   (oADDR_WR),
      .oDATA_WR   (oDATA_WR),
      .oWE_0      (oWE_0),
      .oWE_1      (oWE_1),
      .oWE_2      (oWE_2),
      .oWE_3      (oWE_3),
      .oCNT       (oCNT),
      .oFRAME_DONE(oFRAME_DONE)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int               k;
      int               bank;
      int               addr;
      logic [D_BIT-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   k        = 0;  // position of the next sample in the current frame
   int   n_starts = 0;
   bit   seen[N];

   // Hand-derived placements of a few sample indices.
`ifdef FHT_LOADER_NATURAL_ORDER_EN
   int spot_k[4]    = '{1, 6, 4, 1023};
   int spot_bank[4] = '{1, 2, 0, 3};
   int spot_addr[4] = '{0, 1, 1, 255};
`else
   int spot_k[4]    = '{1, 2, 512, 1023};
   int spot_bank[4] = '{0, 0, 1, 3};
   int spot_addr[4] = '{128, 64, 0, 255};
`endif

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Reference placement: reverse the index digit by digit, then split it.
   function automatic void place(input int idx, output int bank, output int addr);
      int r;
      int t;
`ifdef FHT_LOADER_NATURAL_ORDER_EN
      r = idx;
      t = 0;
`else
      r = 0;
      t = idx;
      for (int i = 0; i < N_BIT; i++) begin
         r = r * 2 + t % 2;
         t = t / 2;
      end
`endif
      bank = r % 4;
      addr = r / 4;
   endfunction

   // Monitor: every write enable pops one expected write.
   initial begin : monitor
      logic [3:0] we;
      exp_t       e;
      int         cur_k;
      int         bank;
      int         nseen;
      bit         prev_done;
      nseen     = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge iCLK);
         if (iRESET) begin
            prev_done = 1'b0;
            continue;
         end
         we    = {oWE_3, oWE_2, oWE_1, oWE_0};
         cur_k = -1;
         if (we != 4'b0) begin
            chk("we_onehot", $countones(we), 1);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", we, 0);
            end else begin
               e     = exp_q.pop_front();
               cur_k = e.k;
               bank  = we[1] ? 1 : we[2] ? 2 : we[3] ? 3 : 0;
               chk("wr_bank", bank, e.bank);
               chk("wr_addr", oADDR_WR, e.addr);
               chk("wr_data", oDATA_WR, e.data);
               for (int i = 0; i < 4; i++) begin
                  if (e.k == spot_k[i]) begin
                     chk("spot_bank", bank, spot_bank[i]);
                     chk("spot_addr", oADDR_WR, spot_addr[i]);
                  end
               end
               if (e.k == 0) begin
                  foreach (seen[i]) seen[i] = 1'b0;
                  nseen = 0;
               end
               chk("dup_pair", seen[e.bank * 256 + e.addr], 0);
               seen[e.bank * 256 + e.addr] = 1'b1;
               nseen++;
            end
         end
         if (oFRAME_DONE || cur_k == N - 1) begin
            chk("frame_done_with_last", oFRAME_DONE && (cur_k == N - 1), 1);
            chk("frame_pairs", nseen, N);
         end
         if (oSTART) begin
            chk("start_after_done", prev_done, 1);
            n_starts++;
         end
         prev_done = oFRAME_DONE;
      end
   end

   // Offer samples until the frame position reaches upto; held data on stalls.
   task automatic stream(input int upto, input int duty);
      int   guard = 0;
      bit   pend  = 1'b0;
      exp_t e;
      while (k < upto && guard < 20000) begin
         @(negedge iCLK);
         guard++;
         if (!pend) begin
            iVALID = ($urandom_range(99) < duty);
            iDATA  = D_BIT'($urandom);
         end
         if (iVALID && oREADY) begin
            chk("cnt_at_accept", oCNT, k % N);
            e.k    = k;
            e.data = iDATA;
            place(k, e.bank, e.addr);
            exp_q.push_back(e);
            k++;
            pend = 1'b0;
         end else begin
            pend = iVALID;
         end
      end
      if (k < upto) chk("stream_timeout", k, upto);
   endtask

   // Called right after the final accept of a frame.
   task automatic wait_start();
      int guard = 0;
      @(negedge iCLK);
      iVALID = 1'($urandom_range(1));
      chk("cnt_wrap", oCNT, 0);
      chk("ready_drop_after_last", oREADY, 0);
      k = 0;
      while (!oSTART && guard < 20) begin
         @(negedge iCLK);
         iVALID = 1'($urandom_range(1));
         guard++;
      end
      chk("start_seen", oSTART, 1);
   endtask

   task automatic resume_controller();
      @(negedge iCLK);
      iVALID   = 1'b0;
      iFHT_RDY = 1'b0;
      repeat (3) @(negedge iCLK);
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      chk("ready_after_run", oREADY, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, oREADY, 0);
      chk({tag, "_start"}, oSTART, 0);
      chk({tag, "_done"}, oFRAME_DONE, 0);
      chk({tag, "_cnt"}, oCNT, 0);
      chk({tag, "_we"}, {oWE_3, oWE_2, oWE_1, oWE_0}, 0);
      chk({tag, "_addr"}, oADDR_WR, 0);
      chk({tag, "_data"}, oDATA_WR, 0);
   endtask

   initial begin : driver
      int ready_hi;
      iRESET   = 1'b1;
      iVALID   = 1'b0;
      iABORT   = 1'b0;
      iFHT_RDY = 1'b0;
      iDATA    = '0;
      repeat (2) @(negedge iCLK);
      chk_all_zero("reset");
      iRESET = 1'b0;
      repeat (2) @(negedge iCLK);
      chk("idle_without_rdy", oREADY, 0);
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      chk("ready_after_idle", oREADY, 1);

      // Frame 1: back-to-back samples.
      stream(N, 100);
      wait_start();

      // Abort in the busy-wait must not restart loading.
      @(negedge iCLK);
      iVALID = 1'b1;
      iABORT = 1'b1;
      @(negedge iCLK);
      iABORT = 1'b0;
      chk("busy_abort_ignored", oREADY, 0);
      @(negedge iCLK);
      chk("busy_abort_ignored2", oREADY, 0);

      // Long FHT run: no loading until the controller is idle again.
      iFHT_RDY = 1'b0;
      ready_hi = 0;
      repeat (2600) begin
         @(negedge iCLK);
         if (oREADY) ready_hi++;
         iVALID = 1'($urandom_range(1));
      end
      chk("ready_low_while_busy", ready_hi, 0);
      iVALID   = 1'b0;
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      chk("ready_after_rdy_rise", oREADY, 1);

      // Frame 2: 50% valid duty.
      stream(N, 50);
      wait_start();
      resume_controller();

      // Abort mid-frame at 300 samples.
      stream(300, 60);
      @(negedge iCLK);
      chk("cnt_before_abort", oCNT, 300);
      iVALID = 1'b1;
      iABORT = 1'b1;
      @(negedge iCLK);
      iABORT = 1'b0;
      iVALID = 1'b0;
      chk("abort_cnt", oCNT, 0);
      chk("abort_we", {oWE_3, oWE_2, oWE_1, oWE_0}, 0);
      chk("abort_ready", oREADY, 0);
      k = 0;
      @(negedge iCLK);
      chk("ready_after_abort", oREADY, 1);

      // Controller starts mid-frame; abort while waiting on it has no effect.
      stream(500, 70);
      @(negedge iCLK);
      iVALID   = 1'b0;
      iFHT_RDY = 1'b0;
      @(negedge iCLK);
      chk("ready_drop_on_rdy_fall", oREADY, 0);
      iABORT = 1'b1;
      @(negedge iCLK);
      iABORT = 1'b0;
      chk("wait_done_abort_cnt", oCNT, 500);
      chk("wait_done_abort_ready", oREADY, 0);
      repeat (3) @(negedge iCLK);
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      chk("resume_ready", oREADY, 1);
      chk("resume_cnt", oCNT, 500);
      stream(N, 70);
      wait_start();
      resume_controller();

      // Asynchronous reset in the middle of a frame.
      stream(700, 80);
      @(negedge iCLK);
      iVALID = 1'b0;
      chk("cnt_before_reset", oCNT, 700);
      @(negedge iCLK);
      @(posedge iCLK);
      #3 iRESET = 1'b1;
      #1 chk_all_zero("async_reset");
      chk("queue_empty_at_reset", exp_q.size(), 0);
      @(negedge iCLK);
      @(negedge iCLK);
      iRESET = 1'b0;
      k      = 0;
      @(negedge iCLK);
      chk("ready_after_reset", oREADY, 1);
      stream(N, 50);
      wait_start();

      repeat (5) @(negedge iCLK);
      chk("queue_empty_end", exp_q.size(), 0);
      chk("start_count", n_starts, 4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
